// File: rtl/if_stage.sv
// rtl/if_stage.sv - RISC-V instruction-fetch stage: PC register, IF/ID pipeline register, fetch counter
//
// Optional feature macro: IF_ECALL_HALT_EN (halt fetch after capturing an ecall word)
//
// Ports:
//   clk              system clock, rising-edge state updates
//   reset            synchronous active-high reset, overrides all other inputs
//   stall            hold pc, IF/ID and fetch_count
//   redirect_valid   load redirect_target (word aligned) into pc and flush IF/ID
//   redirect_target  redirect destination
//   imem_addr        instruction memory address, combinationally equal to pc
//   imem_dout        instruction word returned for imem_addr in the same cycle
//   pc               current program counter
//   if_id_pc         PC of the instruction held in IF/ID
//   if_id_inst       instruction held in IF/ID
//   if_id_valid      IF/ID holds a real instruction rather than a bubble
//   fetch_count      instructions captured with valid=1 since reset (wraps)
//   halted           fetch stopped after an ecall (always 0 without the macro)

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_dout,
    output logic [31:0] pc,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic [31:0] fetch_count,
    output logic        halted
);

    // Targets are forced to word alignment, so the low bits are intentionally dropped.
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^redirect_target[1:0];

    // Memory is asynchronous-read: the address is the PC itself, no register stage.
    assign imem_addr = pc;

`ifdef IF_ECALL_HALT_EN
    localparam logic [31:0] ECALL_INST = 32'h0000_0073;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            halted      <= 1'b0;
            pc          <= RESET_PC;
            if_id_pc    <= 32'h0000_0000;
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
            fetch_count <= 32'h0000_0000;
        end else begin
            case (state)
                HALTED: begin
                    // pc frozen; keep feeding bubbles, ignore stall and redirect.
                    if_id_pc    <= 32'h0000_0000;
                    if_id_inst  <= NOP_INST;
                    if_id_valid <= 1'b0;
                end
                default: begin
                    if (redirect_valid) begin
                        pc          <= {redirect_target[31:2], 2'b00};
                        if_id_pc    <= 32'h0000_0000;
                        if_id_inst  <= NOP_INST;
                        if_id_valid <= 1'b0;
                    end else if (!stall) begin
                        if_id_pc    <= pc;
                        if_id_inst  <= imem_dout;
                        if_id_valid <= 1'b1;
                        fetch_count <= fetch_count + 32'd1;
                        if (imem_dout == ECALL_INST) begin
                            // The ecall itself is delivered; pc stays on it.
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            pc <= pc + 32'd4;
                        end
                    end
                end
            endcase
        end
    end
`else
    assign halted = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            if_id_pc    <= 32'h0000_0000;
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
            fetch_count <= 32'h0000_0000;
        end else if (redirect_valid) begin
            pc          <= {redirect_target[31:2], 2'b00};
            if_id_pc    <= 32'h0000_0000;
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if_id_pc    <= pc;
            if_id_inst  <= imem_dout;
            if_id_valid <= 1'b1;
            pc          <= pc + 32'd4;
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule
